// File: rtl/alu_muldiv_unit_if.sv
// Handshake/operand bundle between the EX stage and the iterative multiply/divide unit.
// The core drives the request side through the master modport; the unit uses the slave modport.
interface alu_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      op_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, src1_i, src2_i, kill_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, src1_i, src2_i, kill_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Radix-2 iterative RV32M multiply/divide unit: XLEN CALC iterations, then a FIN sign-fix/select cycle.
// Optional feature macro MULDIV_EARLY_OUT_EN: trivial operands (x0 multiply, /0, min/-1) skip CALC.
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    alu_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_r, next_state_s;
    logic [2:0]        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   hi_r, lo_r, mcand_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r, done_r;
    logic [XLEN-1:0]   result_r;

    logic              load_s, step_s, fin_s, early_s;
    logic              is_div_s, s1_signed_s, s2_signed_s, neg1_s, neg2_s;
    logic              div_zero_s, ovf_s, mul_zero_s, neg_res_s;
    logic [XLEN-1:0]   mag1_s, mag2_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_trial_s;
    logic [2*XLEN-1:0] prod_s, prod_fix_s;
    logic [XLEN-1:0]   div_val_s, result_s;

    // Decode the incoming request: operand signedness, magnitudes and special cases.
    always_comb begin
        is_div_s    = bus.op_i[2];
        s1_signed_s = is_div_s ? ~bus.op_i[0] : (bus.op_i != 3'b011);
        s2_signed_s = is_div_s ? ~bus.op_i[0] : ~bus.op_i[1];
        neg1_s      = s1_signed_s & bus.src1_i[XLEN-1];
        neg2_s      = s2_signed_s & bus.src2_i[XLEN-1];
        mag1_s      = neg1_s ? -bus.src1_i : bus.src1_i;
        mag2_s      = neg2_s ? -bus.src2_i : bus.src2_i;
        div_zero_s  = (bus.src2_i == {XLEN{1'b0}});
        ovf_s       = is_div_s & ~bus.op_i[0] & (bus.src1_i == MIN_INT) & (bus.src2_i == {XLEN{1'b1}});
        mul_zero_s  = ~is_div_s & ((bus.src1_i == {XLEN{1'b0}}) | div_zero_s);
        // Quotient by zero stays all ones; remainder always takes the dividend's sign.
        if (!is_div_s) begin
            neg_res_s = neg1_s ^ neg2_s;
        end else if (bus.op_i[1]) begin
            neg_res_s = neg1_s;
        end else begin
            neg_res_s = (neg1_s ^ neg2_s) & ~div_zero_s;
        end
`ifdef MULDIV_EARLY_OUT_EN
        early_s = is_div_s ? (div_zero_s | ovf_s) : mul_zero_s;
`else
        early_s = 1'b0;
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring trial subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, mcand_r};
    end

    // Final sign correction and result select, consumed in FIN.
    always_comb begin
        prod_s     = {hi_r, lo_r};
        prod_fix_s = neg_r ? -prod_s : prod_s;
        div_val_s  = op_r[1] ? hi_r : lo_r;
        if (!op_r[2]) begin
            result_s = (op_r == 3'b000) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        end else begin
            result_s = neg_r ? -div_val_s : div_val_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state and datapath control; kill wins over every other transition.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        fin_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.kill_i) begin
                    next_state_s = IDLE;
                end else if (bus.start_i) begin
                    load_s       = 1'b1;
                    next_state_s = early_s ? FIN : CALC;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CALC: begin
                if (bus.kill_i) begin
                    next_state_s = IDLE;
                end else begin
                    step_s       = 1'b1;
                    next_state_s = (cnt_r == {CNT_W{1'b0}}) ? FIN : CALC;
                end
            end
            FIN: begin
                if (bus.kill_i) begin
                    next_state_s = IDLE;
                end else begin
                    fin_s        = 1'b1;
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_r     <= 3'b000;
            neg_r    <= 1'b0;
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            mcand_r  <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            busy_r <= (next_state_s != IDLE);
            done_r <= fin_s;
            if (fin_s) begin
                result_r <= result_s;
            end else begin
                result_r <= result_r;
            end
            if (load_s) begin
                op_r  <= bus.op_i;
                neg_r <= neg_res_s;
                cnt_r <= CNT_W'(XLEN - 1);
                // Early-out preloads hi/lo with the final magnitudes so FIN needs no special path.
                if (is_div_s) begin
                    mcand_r <= mag2_s;
                    hi_r    <= (early_s & div_zero_s) ? mag1_s : {XLEN{1'b0}};
                    lo_r    <= (early_s & div_zero_s) ? {XLEN{1'b1}} : mag1_s;
                end else begin
                    mcand_r <= mag1_s;
                    hi_r    <= {XLEN{1'b0}};
                    lo_r    <= early_s ? {XLEN{1'b0}} : mag2_s;
                end
            end else if (step_s) begin
                cnt_r <= cnt_r - CNT_W'(1);
                if (op_r[2]) begin
                    if (!div_trial_s[XLEN]) begin
                        hi_r <= div_trial_s[XLEN-1:0];
                        lo_r <= {lo_r[XLEN-2:0], 1'b1};
                    end else begin
                        hi_r <= div_shift_s[XLEN-1:0];
                        lo_r <= {lo_r[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_r <= mul_sum_s[XLEN:1];
                    lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
                end
            end else begin
                cnt_r <= cnt_r;
                hi_r  <= hi_r;
                lo_r  <= lo_r;
            end
        end
    end

    assign bus.busy_o   = busy_r;
    assign bus.done_o   = done_r;
    assign bus.result_o = result_r;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed/scoreboard testbench for alu_muldiv_unit (XLEN=32), honours MULDIV_EARLY_OUT_EN.
module tb_alu_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = 32'h0;

    alu_muldiv_unit_if #(.XLEN(32)) bus ();

    alu_muldiv_unit #(.XLEN(32)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        model = 32'h0;
        case (op)
            3'b000: begin up = ua * ub; model = up[31:0]; end
            3'b001: begin sp = sa * sb; model = sp[63:32]; end
            3'b010: begin sp = sa * $signed(ub); model = sp[63:32]; end
            3'b011: begin up = ua * ub; model = up[63:32]; end
            3'b100: if (b == 32'h0) model = 32'hFFFF_FFFF; else begin sp = sa / sb; model = sp[31:0]; end
            3'b101: if (b == 32'h0) model = 32'hFFFF_FFFF; else model = a / b;
            3'b110: if (b == 32'h0) model = a; else begin sp = sa % sb; model = sp[31:0]; end
            3'b111: if (b == 32'h0) model = a; else model = a % b;
            default: model = 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        lat_of = 34;
`ifdef MULDIV_EARLY_OUT_EN
        if (op[2] && (b == 32'h0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) lat_of = 2;
        if (!op[2] && (a == 32'h0 || b == 32'h0)) lat_of = 2;
`endif
    endfunction

    // Drive a request in the current cycle and record its expected result.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        sb_q.push_back(model(op, a, b));
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.src1_i  = a;
        bus.src2_i  = b;
    endtask

    // Wait for the issued request to complete; optionally pulse start while busy.
    task automatic finish_op(input string tag, input int lat, input bit pulse_busy);
        int n;
        logic [31:0] exp;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
        n = 1;
        chk({tag, "_busy"}, {31'h0, bus.busy_o}, 32'h1);
        while (bus.done_o !== 1'b1 && n < 100) begin
            if (pulse_busy && (n == 5 || n == 12)) bus.start_i = 1'b1;
            else bus.start_i = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        bus.start_i = 1'b0;
        chk({tag, "_lat"}, n, lat);
        exp = sb_q.pop_front();
        chk({tag, "_res"}, bus.result_o, exp);
        last_result = exp;
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        issue(op, a, b);
        finish_op(tag, lat_of(op, a, b), 1'b0);
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'h0, bus.done_o}, 32'h0);
    endtask

    initial begin
        int saw;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        bus.start_i = 1'b0;
        bus.op_i    = 3'b000;
        bus.src1_i  = 32'h0;
        bus.src2_i  = 32'h0;
        bus.kill_i  = 1'b0;
        #1;
        chk("rst_busy", {31'h0, bus.busy_o}, 32'h0);
        chk("rst_done", {31'h0, bus.done_o}, 32'h0);
        chk("rst_res", bus.result_o, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run("mul",    3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
        run("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000);
        run("mulhsu", 3'b010, 32'h8000_0000, 32'h8000_0000);
        run("mulhu",  3'b011, 32'h8000_0000, 32'h8000_0000);
        run("div",    3'b100, 32'hFFFF_FFEC, 32'h0000_0006);
        run("rem",    3'b110, 32'hFFFF_FFEC, 32'h0000_0006);
        run("divu",   3'b101, 32'hFFFF_FFFF, 32'h0000_0002);
        run("remu",   3'b111, 32'h0000_0064, 32'h0000_0007);
        run("div0",   3'b100, 32'h0000_0005, 32'h0000_0000);
        run("rem0",   3'b110, 32'h0000_0005, 32'h0000_0000);
        run("divu0",  3'b101, 32'h1234_5678, 32'h0000_0000);
        run("remu0",  3'b111, 32'h1234_5678, 32'h0000_0000);
        run("remneg0",3'b110, 32'hFFFF_FF00, 32'h0000_0000);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run("mulz",   3'b000, 32'h0000_0000, 32'hDEAD_BEEF);
        run("mulhz",  3'b001, 32'hFFFF_FFFF, 32'h0000_0000);

        // Start pulses while busy must be ignored.
        @(negedge clk);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("ignore", 34, 1'b1);

        // Back-to-back: next request issued in the done cycle.
        issue(3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFF9);
        finish_op("b2b1", 34, 1'b0);
        issue(3'b110, 32'h7FFF_FFFF, 32'hFFFF_FFF9);
        finish_op("b2b2", 34, 1'b0);

        // Kill mid-CALC: no done, result held.
        @(negedge clk);
        bus.start_i = 1'b1; bus.op_i = 3'b000; bus.src1_i = 32'h1111_1111; bus.src2_i = 32'h3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.kill_i = 1'b1;
        @(posedge clk); #1;
        bus.kill_i = 1'b0;
        chk("kill_busy", {31'h0, bus.busy_o}, 32'h0);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done_o === 1'b1) saw = 1;
        end
        chk("kill_nodone", saw, 0);
        chk("kill_hold", bus.result_o, last_result);

        // Kill together with start in IDLE: start dropped.
        @(negedge clk);
        bus.start_i = 1'b1; bus.kill_i = 1'b1; bus.op_i = 3'b101; bus.src1_i = 32'h9; bus.src2_i = 32'h2;
        @(posedge clk); #1;
        bus.start_i = 1'b0; bus.kill_i = 1'b0;
        chk("killstart_busy", {31'h0, bus.busy_o}, 32'h0);

        run("afterkill", 3'b101, 32'h0000_0009, 32'h0000_0002);

        // A few random operations through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = (i == 3) ? 32'h0 : $urandom;
            run("rand", rop, ra, rb);
        end

        // Asynchronous reset mid-CALC clears outputs immediately.
        @(negedge clk);
        issue(3'b001, 32'h1234_5678, 32'h8765_4321);
        void'(sb_q.pop_back());
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'h0, bus.busy_o}, 32'h0);
        chk("arst_done", {31'h0, bus.done_o}, 32'h0);
        chk("arst_res", bus.result_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run("afterrst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
